// File: rtl/arc4_param.sv
// ARC4 decrypt core: S-box init, key scheduling and keystream XOR over an internal 256x8 S RAM.
// Messages are length-prefixed; an optional printable check aborts on the first bad byte.
module arc4_param #(
    parameter int KEY_BYTES       = 3,
    parameter bit CHECK_PRINTABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [KEY_BYTES*8-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren,
    output logic                   key_ok
);

    typedef enum logic [4:0] {
        IDLE, INIT,
        KSA_RDI, KSA_WTI, KSA_RDJ, KSA_WTJ, KSA_WRI, KSA_WRJ,
        LEN_RD, LEN_WT,
        PR_RDI, PR_WTI, PR_RDJ, PR_WTJ, PR_WRI, PR_WRJ, PR_RDP, PR_WTP, PR_OUT,
        DONE
    } state_t;

    localparam logic [4:0] KIDX_LAST = 5'(KEY_BYTES - 1);

    state_t                 state_q;
    logic [KEY_BYTES*8-1:0] key_q;
    logic [7:0]             i_q, j_q, si_q, sj_q, len_q;
    logic [4:0]             kidx_q;
    logic [8:0]             k_q;
    logic                   ok_q;
    logic                   rdy_q, key_ok_q, pt_wren_q;
    logic [7:0]             ct_addr_q, pt_addr_q, pt_wrdata_q;

    logic [7:0] s_mem [256];
    logic [7:0] s_rdata_q;
    logic [7:0] s_addr_d, s_wdata_d, key_byte_d, pt_byte_d;
    logic       s_we_d, s_rd_d;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    assign rdy       = rdy_q;
    assign key_ok    = key_ok_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    assign pt_wren   = pt_wren_q;

    assign pt_byte_d = s_rdata_q ^ ct_rddata;

    // Key byte i mod KEY_BYTES, byte 0 in the most significant position.
    always_comb begin
        key_byte_d = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == 5'(b)) key_byte_d = key_q[(KEY_BYTES-1-b)*8 +: 8];
        end
    end

    always_comb begin
        s_addr_d  = i_q;
        s_wdata_d = i_q;
        s_we_d    = 1'b0;
        s_rd_d    = 1'b0;
        case (state_q)
            INIT:             s_we_d = 1'b1;
            KSA_RDI, PR_RDI:  s_rd_d = 1'b1;
            KSA_RDJ, PR_RDJ: begin
                s_rd_d   = 1'b1;
                s_addr_d = j_q;
            end
            KSA_WRI, PR_WRI: begin
                s_we_d    = 1'b1;
                s_wdata_d = sj_q;
            end
            KSA_WRJ, PR_WRJ: begin
                s_we_d    = 1'b1;
                s_addr_d  = j_q;
                s_wdata_d = si_q;
            end
            PR_RDP: begin
                s_rd_d   = 1'b1;
                s_addr_d = si_q + sj_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_we_d)      s_mem[s_addr_d] <= s_wdata_d;
        else if (s_rd_d) s_rdata_q       <= s_mem[s_addr_d];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            key_ok_q    <= 1'b0;
            pt_wren_q   <= 1'b0;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
        end else begin
            pt_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        key_q     <= key;
                        i_q       <= 8'd0;
                        ct_addr_q <= 8'd0;
                        rdy_q     <= 1'b0;
                        state_q   <= INIT;
                    end
                end
                INIT: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        j_q     <= 8'd0;
                        kidx_q  <= 5'd0;
                        state_q <= KSA_RDI;
                    end
                end
                KSA_RDI: state_q <= KSA_WTI;
                KSA_WTI: begin
                    si_q    <= s_rdata_q;
                    j_q     <= j_q + s_rdata_q + key_byte_d;
                    state_q <= KSA_RDJ;
                end
                KSA_RDJ: state_q <= KSA_WTJ;
                KSA_WTJ: begin
                    sj_q    <= s_rdata_q;
                    state_q <= KSA_WRI;
                end
                KSA_WRI: state_q <= KSA_WRJ;
                KSA_WRJ: begin
                    i_q     <= i_q + 8'd1;
                    kidx_q  <= (kidx_q == KIDX_LAST) ? 5'd0 : kidx_q + 5'd1;
                    state_q <= (i_q == 8'hFF) ? LEN_RD : KSA_RDI;
                end
                // ct_addr has been 0 since accept, so ct[0] is on ct_rddata by LEN_WT.
                LEN_RD: state_q <= LEN_WT;
                LEN_WT: begin
                    len_q       <= ct_rddata;
                    pt_wren_q   <= 1'b1;
                    pt_addr_q   <= 8'd0;
                    pt_wrdata_q <= ct_rddata;
                    ok_q        <= 1'b1;
                    i_q         <= 8'd1;
                    j_q         <= 8'd0;
                    k_q         <= 9'd1;
                    ct_addr_q   <= 8'd1;
                    state_q     <= (ct_rddata == 8'd0) ? DONE : PR_RDI;
                end
                PR_RDI: state_q <= PR_WTI;
                PR_WTI: begin
                    si_q    <= s_rdata_q;
                    j_q     <= j_q + s_rdata_q;
                    state_q <= PR_RDJ;
                end
                PR_RDJ: state_q <= PR_WTJ;
                PR_WTJ: begin
                    sj_q    <= s_rdata_q;
                    state_q <= PR_WRI;
                end
                PR_WRI: state_q <= PR_WRJ;
                PR_WRJ: state_q <= PR_RDP;
                PR_RDP: state_q <= PR_WTP;
                PR_WTP: begin
                    if (!CHECK_PRINTABLE || is_printable(pt_byte_d)) begin
                        pt_wren_q   <= 1'b1;
                        pt_addr_q   <= k_q[7:0];
                        pt_wrdata_q <= pt_byte_d;
                        state_q     <= (k_q == {1'b0, len_q}) ? DONE : PR_OUT;
                    end else begin
                        ok_q    <= 1'b0;
                        state_q <= DONE;
                    end
                end
                PR_OUT: begin
                    k_q       <= k_q + 9'd1;
                    i_q       <= i_q + 8'd1;
                    ct_addr_q <= k_q[7:0] + 8'd1;
                    state_q   <= PR_RDI;
                end
                DONE: begin
                    rdy_q    <= 1'b1;
                    key_ok_q <= ok_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_param.sv
// Directed bench for arc4_param: three instances (3-byte key checked, 4-byte key checked,
// 3-byte key unchecked) share one ciphertext memory; the selected instance's writes are logged.
module tb_arc4_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      en_v;
    logic [23:0]     key3;
    logic [31:0]     key4;
    logic [7:0]      ct_mem [256];
    logic [2:0]      rdy_w, key_ok_w, pt_wren_w;
    logic [2:0][7:0] ct_addr_w, ct_rd, pt_addr_w, pt_wrdata_w;

    int n_chk = 0, n_pass = 0;
    int sel = 0, run_id = 0, wr_base = 0, ord_base = 0;
    int wr_cnt = 0, order_err = 0, stray = 0, last_addr = -1, mon_id = 0;
    logic [7:0] pt_mem [256];
    logic [7:0] exp_pt [256];
    logic [7:0] ks [256];

    logic [7:0] T1_CT [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] T1_PT [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] T2_CT [6]  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] T2_PT [6]  = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    logic [7:0] HELLO [6]  = '{8'h05, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    arc4_param #(.KEY_BYTES(3), .CHECK_PRINTABLE(1)) u_k3 (
        .clk(clk), .rst_n(rst), .en(en_v[0]), .rdy(rdy_w[0]), .key(key3),
        .ct_addr(ct_addr_w[0]), .ct_rddata(ct_rd[0]), .pt_addr(pt_addr_w[0]),
        .pt_wrdata(pt_wrdata_w[0]), .pt_wren(pt_wren_w[0]), .key_ok(key_ok_w[0]));

    arc4_param #(.KEY_BYTES(4), .CHECK_PRINTABLE(1)) u_k4 (
        .clk(clk), .rst_n(rst), .en(en_v[1]), .rdy(rdy_w[1]), .key(key4),
        .ct_addr(ct_addr_w[1]), .ct_rddata(ct_rd[1]), .pt_addr(pt_addr_w[1]),
        .pt_wrdata(pt_wrdata_w[1]), .pt_wren(pt_wren_w[1]), .key_ok(key_ok_w[1]));

    arc4_param #(.KEY_BYTES(3), .CHECK_PRINTABLE(0)) u_k3n (
        .clk(clk), .rst_n(rst), .en(en_v[2]), .rdy(rdy_w[2]), .key(key3),
        .ct_addr(ct_addr_w[2]), .ct_rddata(ct_rd[2]), .pt_addr(pt_addr_w[2]),
        .pt_wrdata(pt_wrdata_w[2]), .pt_wren(pt_wren_w[2]), .key_ok(key_ok_w[2]));

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) ct_rd[d] <= ct_mem[ct_addr_w[d]];
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pt_wren_w[d] === 1'b1) begin
                if (d != sel) stray++;
                else begin
                    if (mon_id != run_id) begin
                        mon_id    = run_id;
                        last_addr = -1;
                    end
                    if (int'(pt_addr_w[d]) != last_addr + 1) order_err++;
                    last_addr = int'(pt_addr_w[d]);
                    pt_mem[pt_addr_w[d]] = pt_wrdata_w[d];
                    wr_cnt++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    // Reference keystream: ks[1..n] for a key held in the low klen bytes of kw.
    function automatic void arc4_ks(input logic [255:0] kw, input int klen, input int n);
        int s [256];
        int i, j, t;
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + int'(kw[(klen-1-(a%klen))*8 +: 8])) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int k = 1; k <= n; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[k] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endfunction

    task automatic mark_run(input int d);
        sel      = d;
        run_id++;
        wr_base  = wr_cnt;
        ord_base = order_err;
    endtask

    task automatic begin_run(input string tag, input int d);
        @(negedge clk);
        mark_run(d);
        en_v[d] = 1'b1;
        @(negedge clk);
        en_v[d] = 1'b0;
        check({tag, "_accept"}, 32'(rdy_w[d]), 0);
    endtask

    task automatic wait_rdy(input string tag, input int d, input int len);
        int bound = 2 * (256 + 6*256 + 4 + 10*len + 4);
        int cyc = 0;
        while (rdy_w[d] !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rdy"}, 32'(rdy_w[d]), 1);
    endtask

    task automatic check_run(input string tag, input int d, input int n, input int ok);
        check({tag, "_nwr"}, wr_cnt - wr_base, n);
        check({tag, "_order"}, order_err - ord_base, 0);
        check({tag, "_keyok"}, 32'(key_ok_w[d]), ok);
        for (int a = 0; a < n; a++)
            check($sformatf("%s_pt%0d", tag, a), 32'(pt_mem[a]), 32'(exp_pt[a]));
    endtask

    task automatic load_t1();
        for (int a = 0; a < 10; a++) begin
            ct_mem[a] = T1_CT[a];
            exp_pt[a] = T1_PT[a];
        end
    endtask

    initial begin
        rst  = 1'b1;
        en_v = 3'b000;
        key3 = 24'h4B6579;
        key4 = 32'h57696B69;
        for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_rdy%0d", d),    32'(rdy_w[d]), 1);
            check($sformatf("rst_keyok%0d", d),  32'(key_ok_w[d]), 0);
            check($sformatf("rst_wren%0d", d),   32'(pt_wren_w[d]), 0);
            check($sformatf("rst_ctaddr%0d", d), 32'(ct_addr_w[d]), 0);
            check($sformatf("rst_ptaddr%0d", d), 32'(pt_addr_w[d]), 0);
            check($sformatf("rst_ptdata%0d", d), 32'(pt_wrdata_w[d]), 0);
        end

        // "Key" / "Plaintext"
        load_t1();
        begin_run("t1", 0);
        wait_rdy("t1", 0, 9);
        check_run("t1", 0, 10, 1);

        // "Wiki" / "pedia", then en held across the rdy rise with a new key
        for (int a = 0; a < 6; a++) begin
            ct_mem[a] = T2_CT[a];
            exp_pt[a] = T2_PT[a];
        end
        @(negedge clk);
        mark_run(1);
        en_v[1] = 1'b1;
        @(negedge clk);
        check("t2_accept", 32'(rdy_w[1]), 0);
        key4 = 32'h53656372;
        wait_rdy("t2", 1, 5);
        check_run("t2", 1, 6, 1);
        arc4_ks(256'(32'h53656372), 4, 5);
        ct_mem[0] = 8'h05;
        exp_pt[0] = 8'h05;
        for (int k = 1; k <= 5; k++) begin
            ct_mem[k] = HELLO[k] ^ ks[k];
            exp_pt[k] = HELLO[k];
        end
        mark_run(1);
        @(negedge clk);
        check("t6_accept", 32'(rdy_w[1]), 0);
        en_v[1] = 1'b0;
        wait_rdy("t6", 1, 5);
        check_run("t6", 1, 6, 1);

        // ct[3] decrypts to 0x00: abort when checked, full output when not
        load_t1();
        ct_mem[3] = 8'h77;
        exp_pt[3] = 8'h00;
        begin_run("t3a", 0);
        wait_rdy("t3a", 0, 9);
        check_run("t3a", 0, 3, 0);
        begin_run("t3b", 2);
        wait_rdy("t3b", 2, 9);
        check_run("t3b", 2, 10, 1);

        // Zero length
        ct_mem[0] = 8'h00;
        exp_pt[0] = 8'h00;
        begin_run("t4a", 0);
        wait_rdy("t4a", 0, 0);
        check_run("t4a", 0, 1, 1);

        // Maximum length, random data, unchecked instance
        ct_mem[0] = 8'hFF;
        exp_pt[0] = 8'hFF;
        for (int k = 1; k < 256; k++) ct_mem[k] = 8'($urandom);
        arc4_ks(256'(24'h4B6579), 3, 255);
        for (int k = 1; k < 256; k++) exp_pt[k] = ct_mem[k] ^ ks[k];
        begin_run("t4b", 2);
        wait_rdy("t4b", 2, 255);
        check_run("t4b", 2, 256, 1);
        check("t4b_last", last_addr, 255);

        // Reset during KSA, then a clean run with key/en disturbances after accept
        load_t1();
        begin_run("t5a", 0);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5a_rdy", 32'(rdy_w[0]), 1);
        check("t5a_keyok", 32'(key_ok_w[0]), 0);
        check("t5a_wren", 32'(pt_wren_w[0]), 0);
        repeat (20) @(negedge clk);
        check("t5a_nwr", wr_cnt - wr_base, 0);
        check("t5a_idle", 32'(rdy_w[0]), 1);
        begin_run("t5b", 0);
        key3 = 24'hFFFFFF;
        repeat (50) @(negedge clk);
        en_v[0] = 1'b1;
        @(negedge clk);
        en_v[0] = 1'b0;
        wait_rdy("t5b", 0, 9);
        check_run("t5b", 0, 10, 1);
        key3 = 24'h4B6579;

        check("stray_writes", stray, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
